// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared types and width helpers for the SPU bit-field feeder blocks.
package elixirchip_es1_spu_pkg;

    // Number of words buffered in the two-word window.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Ceiling log2 usable in parameter defaults.
    function automatic int spu_clog2(input int value);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

    // Length requests span 0..W inclusive, so they need one more code than W.
    function automatic int spu_len_bits(input int data_bits);
        return spu_clog2(data_bits + 1);
    endfunction

    // The downstream shifter operates on a 2W window.
    function automatic int spu_shift_bits(input int data_bits);
        return spu_clog2(2 * data_bits);
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_bitfield_window.sv
// Two-word window (cur/nxt) with occupancy tracking.
// Retire shifts nxt into cur; an accepted word lands in the slot left
// free after any retire in the same cycle.
//
// occ       | meaning
// OCC_EMPTY | no words held, cur/nxt are don't-care (cleared)
// OCC_ONE   | cur valid, nxt empty (reads as zero)
// OCC_FULL  | cur and nxt both valid
module elixirchip_es1_spu_bitfield_window
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic                 flush_i,
    input  logic                 retire_i,
    input  logic                 accept_i,
    input  logic [DATA_BITS-1:0] word_i,
    output logic [DATA_BITS-1:0] cur_o,
    output logic [DATA_BITS-1:0] nxt_o,
    output occ_e                 occ_o
);

    logic [DATA_BITS-1:0] cur_q, cur_d;
    logic [DATA_BITS-1:0] nxt_q, nxt_d;
    occ_e                 occ_q, occ_d;
    occ_e                 occ_ret;

    // Next window contents: flush, then retire, then accept into the freed slot.
    always_comb begin
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        occ_d   = occ_q;
        occ_ret = occ_q;
        if (flush_i) begin
            cur_d = '0;
            nxt_d = '0;
            occ_d = OCC_EMPTY;
        end else begin
            if (retire_i) begin
                cur_d   = nxt_q;
                nxt_d   = '0;
                occ_ret = (occ_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
            end
            occ_d = occ_ret;
            if (accept_i) begin
                if (occ_ret == OCC_EMPTY) begin
                    cur_d = word_i;
                    occ_d = OCC_ONE;
                end else begin
                    nxt_d = word_i;
                    occ_d = OCC_FULL;
                end
            end
        end
    end

    // Window registers; reset wins over the clock enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q <= '0;
            nxt_q <= '0;
            occ_q <= OCC_EMPTY;
        end else if (cke) begin
            cur_q <= cur_d;
            nxt_q <= nxt_d;
            occ_q <= occ_d;
        end
    end

    assign cur_o = cur_q;
    assign nxt_o = nxt_q;
    assign occ_o = occ_q;

endmodule

// File: rtl/elixirchip_es1_spu_bitfield_feeder.sv
// Bit-field extractor front end: keeps a two-word window and a bit
// pointer and issues (window, shift, length) to a fixed-latency 2W
// right-shift stage. All fetch/advance/retire sequencing lives here.
module elixirchip_es1_spu_bitfield_feeder
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int    DATA_BITS  = 8,
    parameter int    LEN_BITS   = spu_len_bits(DATA_BITS),
    parameter int    SHIFT_BITS = spu_shift_bits(DATA_BITS),
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cke,
    input  logic [DATA_BITS-1:0]   s_word,
    input  logic                   s_word_valid,
    output logic                   s_word_ready,
    input  logic [LEN_BITS-1:0]    s_len,
    input  logic                   s_len_valid,
    output logic                   s_len_ready,
    input  logic                   s_flush,
    output logic [2*DATA_BITS-1:0] m_data,
    output logic [SHIFT_BITS-1:0]  m_shift,
    output logic [LEN_BITS-1:0]    m_len,
    output logic                   m_valid,
    output logic                   m_clear,
    output logic [1:0]             occupancy
);

    localparam int              PTR_BITS  = spu_clog2(DATA_BITS);
    localparam logic [LEN_BITS:0] W_EXT   = (LEN_BITS + 1)'(DATA_BITS);
    localparam bit              CHECK_EN  = (SIMULATION == "true") || (DEBUG == "true");

    logic [DATA_BITS-1:0]   cur, nxt;
    occ_e                   occ;
    logic [PTR_BITS-1:0]    ptr_q, ptr_d;
    logic [LEN_BITS:0]      p_sum;
    logic                   live, flush_go, issue, retire, accept;

    logic [2*DATA_BITS-1:0] m_data_q;
    logic [SHIFT_BITS-1:0]  m_shift_q;
    logic [LEN_BITS-1:0]    m_len_q;
    logic                   m_valid_q, m_clear_q;

    // Handshake and pointer arithmetic; the extra sum bit keeps ptr+len from wrapping.
    always_comb begin
        live         = cke & ~reset;
        flush_go     = live & s_flush;
        p_sum        = (LEN_BITS + 1)'(ptr_q) + {1'b0, s_len};
        s_word_ready = live & ~s_flush & (occ != OCC_FULL);
        s_len_ready  = live & ~s_flush &
                       ((occ == OCC_FULL) | ((occ == OCC_ONE) & (p_sum <= W_EXT)));
        issue        = s_len_valid & s_len_ready;
        retire       = issue & (p_sum >= W_EXT);
        accept       = s_word_valid & s_word_ready;
        ptr_d        = retire ? PTR_BITS'(p_sum - W_EXT) : PTR_BITS'(p_sum);
    end

    elixirchip_es1_spu_bitfield_window #(
        .DATA_BITS (DATA_BITS)
    ) u_window (
        .clk      (clk),
        .reset    (reset),
        .cke      (cke),
        .flush_i  (flush_go),
        .retire_i (retire),
        .accept_i (accept),
        .word_i   (s_word),
        .cur_o    (cur),
        .nxt_o    (nxt),
        .occ_o    (occ)
    );

    // Pointer and issue registers; outputs hold unless a new request issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= '0;
            m_valid_q <= 1'b0;
            m_clear_q <= 1'b0;
            m_data_q  <= '0;
            m_shift_q <= '0;
            m_len_q   <= '0;
        end else if (cke) begin
            if (s_flush) begin
                ptr_q     <= '0;
                m_valid_q <= 1'b0;
                m_clear_q <= 1'b1;
            end else begin
                m_clear_q <= 1'b0;
                m_valid_q <= issue;
                if (issue) begin
                    m_data_q  <= {nxt, cur};
                    m_shift_q <= SHIFT_BITS'(ptr_q);
                    m_len_q   <= s_len;
                    ptr_q     <= ptr_d;
                end
            end
        end
    end

    // Lengths above W have no defined meaning; flag them in checking builds.
    always_ff @(posedge clk) begin
        if (CHECK_EN && live && s_len_valid) begin
            assert ({1'b0, s_len} <= W_EXT)
                else $error("%s: field length %0d exceeds word width", DEVICE, s_len);
        end
    end

    assign m_data    = m_data_q;
    assign m_shift   = m_shift_q;
    assign m_len     = m_len_q;
    assign m_valid   = m_valid_q;
    assign m_clear   = m_clear_q;
    assign occupancy = occ;

endmodule

// File: tb/tb_elixirchip_es1_spu_bitfield_feeder.sv
// Directed bench for the bit-field feeder with a scoreboard-checked output stream.
module tb_elixirchip_es1_spu_bitfield_feeder;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         cke;
    logic [7:0]   s_word;
    logic         s_word_valid;
    logic         s_word_ready;
    logic [3:0]   s_len;
    logic         s_len_valid;
    logic         s_len_ready;
    logic         s_flush;
    logic [15:0]  m_data;
    logic [3:0]   m_shift;
    logic [3:0]   m_len;
    logic         m_valid;
    logic         m_clear;
    logic [1:0]   occupancy;

    int checks = 0;
    int errors = 0;
    logic last_cke = 1'b0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  shift;
        logic [3:0]  len;
        logic [7:0]  masked;
    } exp_t;
    exp_t sb[$];

    elixirchip_es1_spu_bitfield_feeder #(
        .DATA_BITS  (W),
        .SIMULATION ("true")
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cke          (cke),
        .s_word       (s_word),
        .s_word_valid (s_word_valid),
        .s_word_ready (s_word_ready),
        .s_len        (s_len),
        .s_len_valid  (s_len_valid),
        .s_len_ready  (s_len_ready),
        .s_flush      (s_flush),
        .m_data       (m_data),
        .m_shift      (m_shift),
        .m_len        (m_len),
        .m_valid      (m_valid),
        .m_clear      (m_clear),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic [15:0] d, input logic [3:0] sh,
                              input logic [3:0] len, input logic [7:0] m);
        exp_t e;
        e.data = d; e.shift = sh; e.len = len; e.masked = m;
        sb.push_back(e);
    endtask

    // A new output is presented when m_valid is high after an enabled edge.
    always @(posedge clk) last_cke <= cke && !reset;

    always @(negedge clk) begin
        if (m_valid && last_cke) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual data=0x%0h required none", m_data);
            end else begin
                exp_t e;
                logic [31:0] shifted, mask;
                e = sb.pop_front();
                shifted = 32'(m_data) >> m_shift;
                mask    = (32'd1 << m_len) - 32'd1;
                chk("m_data",  32'(m_data),  32'(e.data));
                chk("m_shift", 32'(m_shift), 32'(e.shift));
                chk("m_len",   32'(m_len),   32'(e.len));
                chk("masked",  shifted & mask, 32'(e.masked));
            end
        end
    end

    // Empty window must always have the pointer parked at bit 0.
    always @(negedge clk) begin
        if (!reset && occupancy == 2'd0)
            chk("occ0_ptr0", 32'(dut.ptr_q), 32'd0);
    end

    task automatic push_word(input logic [7:0] w);
        s_word = w;
        s_word_valid = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (s_word_ready) begin
                @(negedge clk);
                s_word_valid = 1'b0;
                #1;
                return;
            end
            @(negedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL push_word_timeout actual=no_ready required=ready word=0x%0h", w);
        s_word_valid = 1'b0;
    endtask

    task automatic send_len(input logic [3:0] len, input logic [15:0] d,
                            input logic [3:0] sh, input logic [7:0] m);
        expect_out(d, sh, len, m);
        s_len = len;
        s_len_valid = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (s_len_ready) begin
                @(negedge clk);
                s_len_valid = 1'b0;
                #1;
                return;
            end
            @(negedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send_len_timeout actual=no_ready required=ready len=%0d", len);
        s_len_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cke = 1'b1; s_flush = 1'b0;
        s_word = 8'h00; s_word_valid = 1'b1;
        s_len = 4'd1; s_len_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_word_ready", 32'(s_word_ready), 0);
        chk("rst_len_ready",  32'(s_len_ready),  0);
        chk("rst_m_valid",    32'(m_valid),      0);
        chk("rst_m_clear",    32'(m_clear),      0);
        chk("rst_m_data",     32'(m_data),       0);
        chk("rst_occ",        32'(occupancy),    0);
        reset = 1'b0; s_word_valid = 1'b0; s_len_valid = 1'b0;
        @(negedge clk);
        #1;

        // 1: two words, four nibble fields
        push_word(8'hA5);
        push_word(8'h3C);
        chk("t1_occ_full", 32'(occupancy), 2);
        send_len(4'd4, 16'h3CA5, 4'd0, 8'h5);
        send_len(4'd4, 16'h3CA5, 4'd4, 8'hA);
        send_len(4'd4, 16'h003C, 4'd0, 8'hC);
        send_len(4'd4, 16'h003C, 4'd4, 8'h3);
        chk("t1_occ_end", 32'(occupancy), 0);

        // 2: request spanning into a word not yet present
        push_word(8'h96);
        send_len(4'd6, 16'h0096, 4'd0, 8'h16);
        expect_out(16'h5A96, 4'd6, 4'd4, 8'hA);
        s_len = 4'd4; s_len_valid = 1'b1;
        #1;
        chk("t2_len_stall0", 32'(s_len_ready), 0);
        @(negedge clk); #1;
        chk("t2_len_stall1", 32'(s_len_ready), 0);
        push_word(8'h5A);
        chk("t2_len_ready", 32'(s_len_ready), 1);
        @(negedge clk);
        s_len_valid = 1'b0;
        #1;
        chk("t2_occ", 32'(occupancy), 1);
        send_len(4'd1, 16'h005A, 4'd2, 8'h0);

        // 4: word accept coinciding with a retire from occ=1, ptr=3
        expect_out(16'h005A, 4'd3, 4'd5, 8'h0B);
        s_len = 4'd5; s_len_valid = 1'b1;
        s_word = 8'hC3; s_word_valid = 1'b1;
        #1;
        chk("t4_len_ready",  32'(s_len_ready),  1);
        chk("t4_word_ready", 32'(s_word_ready), 1);
        @(negedge clk);
        s_len_valid = 1'b0; s_word_valid = 1'b0;
        #1;
        chk("t4_occ", 32'(occupancy), 1);
        send_len(4'd8, 16'h00C3, 4'd0, 8'hC3);
        chk("t4_occ_end", 32'(occupancy), 0);

        // 3: full window, retire while a word is offered
        push_word(8'h11);
        push_word(8'h22);
        expect_out(16'h2211, 4'd0, 4'd8, 8'h11);
        s_len = 4'd8; s_len_valid = 1'b1;
        s_word = 8'h33; s_word_valid = 1'b1;
        #1;
        chk("t3_word_blocked", 32'(s_word_ready), 0);
        chk("t3_len_ready",    32'(s_len_ready),  1);
        @(negedge clk);
        s_len_valid = 1'b0;
        #1;
        chk("t3_word_ready", 32'(s_word_ready), 1);
        chk("t3_occ_mid",    32'(occupancy),    1);
        @(negedge clk);
        s_word_valid = 1'b0;
        #1;
        chk("t3_occ_full", 32'(occupancy), 2);
        send_len(4'd3, 16'h3322, 4'd0, 8'h2);
        send_len(4'd2, 16'h3322, 4'd3, 8'h0);

        // 5: flush with occ=2, ptr=5
        s_flush = 1'b1;
        s_len = 4'd1; s_len_valid = 1'b1;
        s_word = 8'h44; s_word_valid = 1'b1;
        #1;
        chk("t5_len_ready",  32'(s_len_ready),  0);
        chk("t5_word_ready", 32'(s_word_ready), 0);
        @(negedge clk);
        s_flush = 1'b0; s_len_valid = 1'b0; s_word_valid = 1'b0;
        #1;
        chk("t5_occ",     32'(occupancy), 0);
        chk("t5_m_clear", 32'(m_clear),   1);
        chk("t5_m_valid", 32'(m_valid),   0);
        @(negedge clk); #1;
        chk("t5_m_clear_drop", 32'(m_clear), 0);

        // 6: clock-enable stall, then reset mid-operation
        push_word(8'h81);
        push_word(8'h7E);
        send_len(4'd2, 16'h7E81, 4'd0, 8'h1);
        expect_out(16'h7E81, 4'd2, 4'd3, 8'h0);
        s_len = 4'd3; s_len_valid = 1'b1;
        #1;
        chk("t6_len_ready", 32'(s_len_ready), 1);
        @(negedge clk);
        s_len_valid = 1'b0;
        cke = 1'b0;
        s_word = 8'h55; s_word_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t6_hold_valid", 32'(m_valid),      1);
            chk("t6_hold_shift", 32'(m_shift),      2);
            chk("t6_hold_data",  32'(m_data),       32'h7E81);
            chk("t6_hold_occ",   32'(occupancy),    2);
            chk("t6_word_ready", 32'(s_word_ready), 0);
            @(negedge clk); #1;
        end
        cke = 1'b1;
        reset = 1'b1;
        s_len = 4'd1; s_len_valid = 1'b1;
        #1;
        chk("t6_rst_word_ready", 32'(s_word_ready), 0);
        chk("t6_rst_len_ready",  32'(s_len_ready),  0);
        @(negedge clk); #1;
        chk("t6_rst_m_valid", 32'(m_valid),   0);
        chk("t6_rst_m_data",  32'(m_data),    0);
        chk("t6_rst_m_shift", 32'(m_shift),   0);
        chk("t6_rst_m_len",   32'(m_len),     0);
        chk("t6_rst_m_clear", 32'(m_clear),   0);
        chk("t6_rst_occ",     32'(occupancy), 0);
        reset = 1'b0; s_len_valid = 1'b0; s_word_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
